aes_key_expand: RTL and testbench
=================================

Name: aes_key_expand

Overview:
- Upstream key-schedule stage for aes_encrypt.
- Takes a 128/192/256-bit cipher key and generates the FIPS-197 expanded key one 32-bit word per cycle into an internal 60-word buffer.
- Serves round keys to the encrypt core through its subkey / subkey_addr / subkey_valid interface.
- Round key k becomes available as soon as words 4k..4k+3 exist, so encryption can overlap expansion.

Parameters:
- MAX_WORDS, 60, depth of the word buffer (4*(14+1)); fixed by AES-256, not to be reduced.

Ports:
- clk  input  1  clock; all state updates on posedge.
- reset  input  1  synchronous, active-high reset.
- key  input  256  cipher key. Word j is key[32j+31:32j]; byte r of word j (FIPS byte order, r=0 first) is key[32j+8r+7:32j+8r]. Only words 0..Nk-1 are used.
- key_len  input  3  one-hot key size: bit0=128, bit1=192, bit2=256. Priority bit2>bit1>bit0; 0 means no request.
- start  input  1  begin expansion; sampled with key/key_len.
- subkey_addr  input  4  round-key index requested by the consumer.
- subkey  output  128  round key subkey_addr in state layout: byte (4r+c), bits [8(4r+c)+7:8(4r+c)], equals byte r of word 4*addr+c.
- subkey_valid  output  1  subkey is complete and legal for the current subkey_addr.
- busy  output  1  expansion in progress.
- done  output  1  full schedule present.

Behaviour:
- Reset: state=IDLE, word_cnt=0, busy=0, done=0, subkey_valid=0. Buffer contents don't care. subkey reads from the buffer and is don't-care while invalid.
- Decode at start: Nk=8/Nr=14 (bit2), Nk=6/Nr=12 (bit1), Nk=4/Nr=10 (bit0). Total words T=4(Nr+1)=60/52/44.
- FSM states: IDLE, EXPAND, DONE.
- IDLE or DONE, with start=1 and |key_len:
  - copy words 0..Nk-1 into the buffer in one cycle;
  - word_cnt<=Nk, latch Nk/Nr, clear done, set busy, go to EXPAND.
- start with key_len==0 is ignored. start in EXPAND is ignored; key and key_len are not re-sampled.
- EXPAND, each cycle, generate word i=word_cnt:
  - t=w[i-1];
  - if i mod Nk==0: t=SubWord(RotWord(t)) ^ {Rcon[i/Nk] in byte 0}.
  - else if Nk==8 and i mod 8==4: t=SubWord(t).
  - w[i]=w[i-Nk]^t; word_cnt<=i+1.
- i mod Nk and the Rcon index are held in dedicated counters; no dividers.
- RotWord: out byte r = in byte (r+1) mod 4.
- SubWord: 4 instances of the team's composite-field AES S-box.
- Rcon sequence: 01,02,04,08,10,20,40,80,1b,36.
- When word_cnt reaches T-1 and that word is written: next state DONE, busy=0, done=1.
- Latency from start cycle to done=1: 1+T-Nk cycles, i.e. 41 (128), 47 (192), 53 (256).
- subkey_valid is combinational and true iff all of:
  - state != IDLE;
  - subkey_addr <= Nr;
  - word_cnt >= 4*subkey_addr+4.
- subkey is a combinational read, so the consumer may change subkey_addr every cycle.
- Address beyond Nr: subkey_valid=0 forever (the consumer stalls; no error flag).
- Restart from DONE: valid drops the cycle after start for all addresses except round 0 (valid again immediately, since Nk>=4 words are loaded at once). The old schedule is lost.
- Reset mid-EXPAND returns to IDLE next edge. valid, busy and done are 0 the cycle after reset is sampled.
- Simultaneous reset and start: reset wins.

Test Plan:
- AES-128, key words 2b7e1516 28aed2a6 abf71588 09cf4f3c, key_len=001 -> done 41 cycles after start; addr 1 gives words a0fafe17 88542cb1 23a33939 2a6c7605; addr 10 gives d014f9a8 c9ee2589 e13f0cc8 b6630ca6.
- AES-192, key 8e73b0f7 da0e6452 c810f32b 809079e5 62f8ead2 522c6b7b, key_len=010 -> done after 47 cycles; addr 12 gives e98ba06f 448c773c 8ecc7204 01002202; addr 13 never valid.
- AES-256, key 603deb10 15ca71be 2b73aef0 857d7781 1f352c07 3b6108d7 2d9810a3 0914dff4, key_len=100 -> done after 53 cycles; addr 14 gives fe4890d1 e6188d0b 046df344 706c631e.
- Overlap, 128-bit, addr held at 2 from start -> subkey_valid rises exactly when word_cnt=12 (cycle 9 after start) and never before; addr 0 valid the cycle after start.
- Control: start with key_len=000 -> stays IDLE, valid=0. A second start mid-EXPAND with a different key -> ignored, and the original vectors are produced.
- Reset at cycle 20 of a 256-bit expansion -> IDLE, busy=done=valid=0 next cycle. A fresh 128-bit start then yields the scenario-1 vectors.

Source files
------------

// File: rtl/aes_key_expand_if.sv
// Port bundle between the AES key-schedule stage and its requester/consumer.
// The key request and the round-key read port share one bundle.
interface aes_key_expand_if;
    logic [255:0] key;
    logic [2:0]   key_len;
    logic         start;
    logic [3:0]   subkey_addr;
    logic [127:0] subkey;
    logic         subkey_valid;
    logic         busy;
    logic         done;

    // Request side: start is taken on any edge where the FSM is IDLE/DONE and key_len != 0.
    // Read side: subkey is a combinational read of round subkey_addr. It may be used only in
    // a cycle where subkey_valid is high; the consumer stalls (holds subkey_addr) until then.
    modport master (output key, key_len, start, subkey_addr,
                    input  subkey, subkey_valid, busy, done);
    modport slave  (input  key, key_len, start, subkey_addr,
                    output subkey, subkey_valid, busy, done);
endinterface

// File: rtl/aes_key_expand.sv
// AES key expansion (128/192/256): one 32-bit schedule word per cycle into a word buffer,
// round keys readable as soon as their four words exist.
module aes_key_expand #(
    parameter int MAX_WORDS = 60
) (
    input  logic                   clk,
    input  logic                   reset,
    aes_key_expand_if.slave        kx,
    output logic [1:0]             dbg_state_o
);
    typedef enum logic [1:0] {IDLE = 2'd0, EXPAND = 2'd1, DONE = 2'd2} state_t;

    state_t      state_q, state_d;
    logic [5:0]  word_cnt_q, word_cnt_d;
    logic [3:0]  nk_q, nk_d, nr_q, nr_d;
    logic [2:0]  mod_q, mod_d;
    logic [7:0]  rcon_q, rcon_d;
    logic [31:0] w_q [MAX_WORDS];

    logic        load, gen;
    logic [3:0]  nk_new, nr_new;
    logic [5:0]  last_idx;
    logic [31:0] prev_w, back_w, sub_in, sub_out, new_w;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // Inverse via the x^254 addition chain (0 maps to 0), then the affine transform.
    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] a2, a3, a6, a12, a15, a240, inv;
        a2   = gf_mul(a, a);
        a3   = gf_mul(a2, a);
        a6   = gf_mul(a3, a3);
        a12  = gf_mul(a6, a6);
        a15  = gf_mul(a12, a3);
        a240 = gf_mul(a15, a15);
        a240 = gf_mul(a240, a240);
        a240 = gf_mul(a240, a240);
        a240 = gf_mul(a240, a240);
        inv  = gf_mul(gf_mul(a240, a12), a2);
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    always_comb begin
        nk_new = 4'd4;
        nr_new = 4'd10;
        if (kx.key_len[2]) begin
            nk_new = 4'd8;
            nr_new = 4'd14;
        end else if (kx.key_len[1]) begin
            nk_new = 4'd6;
            nr_new = 4'd12;
        end
    end

    assign last_idx = {nr_q, 2'b00} + 6'd3;

    // Byte 0 sits in the low bits, so RotWord is a right rotate by one byte.
    always_comb begin
        prev_w  = w_q[word_cnt_q - 6'd1];
        back_w  = w_q[word_cnt_q - {2'b00, nk_q}];
        sub_in  = (mod_q == 3'd0) ? {prev_w[7:0], prev_w[31:8]} : prev_w;
        sub_out = sub_word(sub_in);
        if (mod_q == 3'd0)
            new_w = back_w ^ sub_out ^ {24'h000000, rcon_q};
        else if (nk_q == 4'd8 && mod_q == 3'd4)
            new_w = back_w ^ sub_out;
        else
            new_w = back_w ^ prev_w;
    end

    always_comb begin
        state_d    = state_q;
        word_cnt_d = word_cnt_q;
        nk_d       = nk_q;
        nr_d       = nr_q;
        mod_d      = mod_q;
        rcon_d     = rcon_q;
        load       = 1'b0;
        gen        = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (kx.start && (|kx.key_len)) begin
                    load       = 1'b1;
                    state_d    = EXPAND;
                    word_cnt_d = {2'b00, nk_new};
                    nk_d       = nk_new;
                    nr_d       = nr_new;
                    mod_d      = 3'd0;
                    rcon_d     = 8'h01;
                end
            end
            EXPAND: begin
                gen        = 1'b1;
                word_cnt_d = word_cnt_q + 6'd1;
                mod_d      = ({1'b0, mod_q} == nk_q - 4'd1) ? 3'd0 : mod_q + 3'd1;
                if (mod_q == 3'd0) rcon_d = xtime(rcon_q);
                if (word_cnt_q == last_idx) state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            word_cnt_q <= '0;
            nk_q       <= 4'd4;
            nr_q       <= 4'd10;
            mod_q      <= '0;
            rcon_q     <= 8'h01;
        end else begin
            state_q    <= state_d;
            word_cnt_q <= word_cnt_d;
            nk_q       <= nk_d;
            nr_q       <= nr_d;
            mod_q      <= mod_d;
            rcon_q     <= rcon_d;
        end
    end

    // One write port per buffer word; only the first eight can be loaded from the key.
    for (genvar g = 0; g < MAX_WORDS; g++) begin : g_buf
        if (g < 8) begin : g_key
            always_ff @(posedge clk) begin
                if (load && (4'(g) < nk_new))
                    w_q[g] <= kx.key[32*g+31 -: 32];
                else if (gen && word_cnt_q == 6'(g))
                    w_q[g] <= new_w;
            end
        end else begin : g_exp
            always_ff @(posedge clk) begin
                if (gen && word_cnt_q == 6'(g))
                    w_q[g] <= new_w;
            end
        end
    end

    always_comb begin
        kx.subkey = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                kx.subkey[8*(4*r+c) +: 8] = w_q[{kx.subkey_addr, 2'b00} + 6'(c)][8*r +: 8];
    end

    assign kx.subkey_valid = (state_q != IDLE) && (kx.subkey_addr <= nr_q) &&
                             ({1'b0, word_cnt_q} >= {1'b0, kx.subkey_addr, 2'b00} + 7'd4);
    assign kx.busy         = (state_q == EXPAND);
    assign kx.done         = (state_q == DONE);
    assign dbg_state_o     = state_q;
endmodule

// File: tb/tb_aes_key_expand.sv
// Bench for aes_key_expand: FIPS-197 vectors, control corner cases and random keys
// checked against a word-level key-schedule model.
module tb_aes_key_expand;
    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] dbg_state;

    aes_key_expand_if kx();

    aes_key_expand #(.MAX_WORDS(60)) dut (
        .clk         (clk),
        .reset       (reset),
        .kx          (kx),
        .dbg_state_o (dbg_state)
    );

    always #5 clk = ~clk;

    int           n_checks = 0;
    int           n_fail   = 0;
    logic [127:0] exp_q[$];
    logic [3:0]   addr_q[$];
    logic [31:0]  mw [60];
    logic [7:0]   sbox_t [256];

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // S-box table from the generator walk: p steps by *3, q by /3, sbox[p] = affine(q).
    task automatic build_sbox();
        logic [7:0] p, q, x;
        p = 8'h01;
        q = 8'h01;
        do begin
            p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
            q = q ^ {q[6:0], 1'b0};
            q = q ^ {q[5:0], 2'b00};
            q = q ^ {q[3:0], 4'b0000};
            if (q[7]) q = q ^ 8'h09;
            x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
            sbox_t[p] = x ^ 8'h63;
        end while (p != 8'h01);
        sbox_t[0] = 8'h63;
    endtask

    function automatic logic [31:0] m_sub(input logic [31:0] w);
        return {sbox_t[w[31:24]], sbox_t[w[23:16]], sbox_t[w[15:8]], sbox_t[w[7:0]]};
    endfunction

    function automatic logic [7:0] m_rcon(input int n);
        logic [7:0] r;
        r = 8'h01;
        for (int i = 1; i < n; i++) r = {r[6:0], 1'b0} ^ (r[7] ? 8'h1b : 8'h00);
        return r;
    endfunction

    function automatic int nk_of(input logic [2:0] kl);
        return kl[2] ? 8 : (kl[1] ? 6 : 4);
    endfunction

    task automatic model_expand(input logic [255:0] k, input int nk);
        int t;
        logic [31:0] tmp;
        t = 4 * (nk + 7);
        for (int i = 0; i < nk; i++) mw[i] = k[32*i +: 32];
        for (int i = nk; i < t; i++) begin
            tmp = mw[i-1];
            if (i % nk == 0)
                tmp = m_sub({tmp[7:0], tmp[31:8]}) ^ {24'h0, m_rcon(i / nk)};
            else if (nk == 8 && i % nk == 4)
                tmp = m_sub(tmp);
            mw[i] = mw[i-nk] ^ tmp;
        end
    endtask

    function automatic logic [127:0] model_rk(input int a);
        logic [127:0] rk;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                rk[8*(4*r+c) +: 8] = mw[4*a+c][8*r +: 8];
        return rk;
    endfunction

    function automatic logic [31:0] fips2w(input logic [31:0] x);
        return {x[7:0], x[15:8], x[23:16], x[31:24]};
    endfunction

    // Key from FIPS-printed words, word 0 leftmost.
    function automatic logic [255:0] mk_key(input logic [255:0] f);
        logic [255:0] k;
        for (int j = 0; j < 8; j++) k[32*j +: 32] = fips2w(f[255-32*j -: 32]);
        return k;
    endfunction

    function automatic logic [127:0] rk_of(input logic [127:0] f);
        logic [127:0] rk;
        logic [31:0]  w;
        for (int c = 0; c < 4; c++) begin
            w = fips2w(f[127-32*c -: 32]);
            for (int r = 0; r < 4; r++) rk[8*(4*r+c) +: 8] = w[8*r +: 8];
        end
        return rk;
    endfunction

    // Monitor: compares whenever the DUT presents a valid round key for the pending request.
    always @(negedge clk) begin
        if (exp_q.size() > 0 && kx.subkey_valid && kx.subkey_addr == addr_q[0]) begin
            check("subkey_sb", kx.subkey, exp_q.pop_front());
            void'(addr_q.pop_front());
        end
    end

    // All driver tasks start and end at posedge+1.
    task automatic do_start(input logic [255:0] k, input logic [2:0] kl);
        kx.key     = k;
        kx.key_len = kl;
        kx.start   = 1'b1;
        if (kl != 3'b000) model_expand(k, nk_of(kl));
        @(posedge clk); #1;
        kx.start   = 1'b0;
    endtask

    task automatic wait_done(input int c0, input int exp_lat);
        int c;
        c = c0;
        while (c < 200) begin
            @(negedge clk);
            if (kx.done) break;
            @(posedge clk); #1;
            c++;
        end
        check("done_latency", 128'(c), 128'(exp_lat));
        @(posedge clk); #1;
    endtask

    task automatic read_rk(input int a);
        exp_q.push_back(model_rk(a));
        addr_q.push_back(4'(a));
        kx.subkey_addr = 4'(a);
        for (int i = 0; i < 100 && exp_q.size() > 0; i++) @(posedge clk);
        #1;
        if (exp_q.size() > 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL rk_timeout: addr %0d got no subkey_valid in 100 cycles, required valid", a);
            exp_q.delete();
            addr_q.delete();
        end
    endtask

    task automatic known(input string nm, input int a, input logic [127:0] f);
        kx.subkey_addr = 4'(a);
        @(negedge clk);
        check({nm, "_valid"}, 128'(kx.subkey_valid), 128'(1));
        check(nm, kx.subkey, rk_of(f));
        @(posedge clk); #1;
    endtask

    task automatic idle_flags(input string nm);
        kx.subkey_addr = 4'd0;
        @(negedge clk);
        check({nm, "_state"}, 128'(dbg_state), 128'(0));
        check({nm, "_busy_done_valid"}, 128'({kx.busy, kx.done, kx.subkey_valid}), 128'(0));
        @(posedge clk); #1;
    endtask

    localparam logic [255:0] K128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
    localparam logic [255:0] K192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
    localparam logic [255:0] K256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
    localparam logic [127:0] R128_1  = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] R128_10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] R192_12 = 128'he98ba06f448c773c8ecc720401002202;
    localparam logic [127:0] R256_14 = 128'hfe4890d1e6188d0b046df344706c631e;

    initial begin
        int first_v;
        int bad;
        logic [255:0] rk;
        logic [2:0]   kl;
        int nk;
        int nr;

        build_sbox();
        reset          = 1'b1;
        kx.key         = '0;
        kx.key_len     = 3'b000;
        kx.start       = 1'b0;
        kx.subkey_addr = 4'd0;
        @(posedge clk); #1;
        idle_flags("reset");
        reset = 1'b0;

        // start with key_len 0 is ignored
        do_start(mk_key(K128), 3'b000);
        repeat (2) @(posedge clk);
        #1;
        idle_flags("no_len");

        // AES-128 vector, full scoreboard sweep
        do_start(mk_key(K128), 3'b001);
        wait_done(1, 41);
        known("v128_r1", 1, R128_1);
        known("v128_r10", 10, R128_10);
        for (int a = 0; a <= 10; a++) read_rk(a);

        // AES-192 vector, address 13 must never be valid
        do_start(mk_key(K192), 3'b010);
        wait_done(1, 47);
        known("v192_r12", 12, R192_12);
        kx.subkey_addr = 4'd13;
        bad = 0;
        repeat (5) begin
            @(negedge clk);
            if (kx.subkey_valid) bad++;
        end
        check("v192_r13_never_valid", 128'(bad), 128'(0));
        @(posedge clk); #1;
        for (int a = 0; a <= 12; a++) read_rk(a);

        // AES-256 vector
        do_start(mk_key(K256), 3'b100);
        wait_done(1, 53);
        known("v256_r14", 14, R256_14);
        for (int a = 0; a <= 14; a++) read_rk(a);

        // overlap: round 2 appears exactly at cycle 9
        kx.subkey_addr = 4'd2;
        do_start(mk_key(K128), 3'b001);
        first_v = 0;
        for (int c = 1; c <= 12 && first_v == 0; c++) begin
            @(negedge clk);
            if (kx.subkey_valid) begin
                first_v = c;
                check("overlap_r2_key", kx.subkey, model_rk(2));
            end
            @(posedge clk); #1;
        end
        check("overlap_r2_first_cycle", 128'(first_v), 128'(9));
        wait_done(first_v + 1, 41);

        // restart from DONE: round 0 valid at once, round 1 not
        kx.subkey_addr = 4'd0;
        do_start(mk_key(K128), 3'b001);
        @(negedge clk);
        check("restart_r0_valid", 128'(kx.subkey_valid), 128'(1));
        check("restart_r0_key", kx.subkey, model_rk(0));
        kx.subkey_addr = 4'd1;
        #1;
        check("restart_r1_invalid", 128'(kx.subkey_valid), 128'(0));
        @(posedge clk); #1;
        wait_done(2, 41);

        // second start mid-EXPAND with another key is ignored
        do_start(mk_key(K128), 3'b001);
        repeat (9) @(posedge clk);
        #1;
        kx.key     = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        kx.key_len = 3'b100;
        kx.start   = 1'b1;
        @(posedge clk); #1;
        kx.start   = 1'b0;
        wait_done(11, 41);
        known("ignored_start_r10", 10, R128_10);
        known("ignored_start_r1", 1, R128_1);

        // reset in cycle 20 of a 256-bit expansion, then a fresh 128-bit run
        do_start(mk_key(K256), 3'b100);
        repeat (19) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        idle_flags("mid_reset");
        do_start(mk_key(K128), 3'b001);
        wait_done(1, 41);
        known("post_reset_r1", 1, R128_1);
        known("post_reset_r10", 10, R128_10);

        // reset and start together: reset wins
        reset      = 1'b1;
        kx.key_len = 3'b001;
        kx.start   = 1'b1;
        @(posedge clk); #1;
        reset      = 1'b0;
        kx.start   = 1'b0;
        idle_flags("reset_vs_start");

        // random keys and key_len (priority decode), reads issued during expansion
        for (int it = 0; it < 6; it++) begin
            rk = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            kl = 3'($urandom_range(1, 7));
            nk = nk_of(kl);
            nr = nk + 6;
            do_start(rk, kl);
            for (int j = 0; j < 3; j++) read_rk($urandom_range(0, nr));
            read_rk(nr);
            first_v = 0;
            for (int c = 0; c < 80 && first_v == 0; c++) begin
                @(negedge clk);
                if (kx.done) first_v = 1;
                @(posedge clk); #1;
            end
            check("rand_done", 128'(first_v), 128'(1));
            for (int j = 0; j < 4; j++) read_rk($urandom_range(0, nr));
            if (nr < 15) begin
                kx.subkey_addr = 4'($urandom_range(nr + 1, 15));
                @(negedge clk);
                check("rand_addr_beyond_nr", 128'(kx.subkey_valid), 128'(0));
                @(posedge clk); #1;
            end
        end

        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
